// File: rtl/rom_sdram_arbiter.sv
// rom_sdram_arbiter: shares one SDRAM controller port between the sprite,
// tile and sound ROM readers, and passes HPS ROM-download writes through.
// Each read is latched, arbitrated and issued as a burst. The READY handshake
// is tracked by an FSM, and read data returns with a one-cycle valid strobe.
// Optional build macro ROM_ARB_AGING_EN: adds per-port starvation counters
// that promote a long-waiting port above the fixed spr > tile > snd order.
module rom_sdram_arbiter #(
  parameter logic [25:0] SPR_BASE  = 26'h0100000,
  parameter logic [25:0] TILE_BASE = 26'h0000000,
  parameter logic [25:0] SND_BASE  = 26'h0200000,
`ifdef ROM_ARB_AGING_EN
  parameter int unsigned STARVE_LIMIT = 4,
`endif
  parameter int unsigned WDOG_MAX  = 255
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        spr_req,
  input  logic [18:0] spr_addr,
  output logic [31:0] spr_data,
  output logic        spr_valid,
  input  logic        tile_req,
  input  logic [17:0] tile_addr,
  output logic [31:0] tile_data,
  output logic        tile_valid,
  input  logic        snd_req,
  input  logic [19:0] snd_addr,
  output logic [15:0] snd_data,
  output logic        snd_valid,
  output logic        SDRAM_RD,
  output logic        SDRAM_WR,
  output logic        SDRAM_BURST,
  output logic [25:0] SDRAM_ADDR,
  output logic [15:0] SDRAM_DIN,
  output logic [1:0]  SDRAM_BS,
  input  logic [63:0] SDRAM_DOUT,
  input  logic        SDRAM_READY,
  input  logic        DL_EN,
  input  logic [26:0] DL_ADDR,
  input  logic [15:0] DL_DATA,
  input  logic        DL_WR,
  output logic        wdog_err
);

  localparam int unsigned NPORT  = 3;
  localparam int unsigned AW     = 26;
  localparam int unsigned WDOG_W = (WDOG_MAX > 2) ? $clog2(WDOG_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    WR_WAIT
  } state_t;

  state_t                       state;
  logic [NPORT-1:0]             pend_q;
  logic [NPORT-1:0][AW-1:0]     addr_q;
  logic [NPORT-1:0]             gnt_oh_q;
  logic                         quiet_q;
  logic [WDOG_W-1:0]            wdog_cnt;

  logic [NPORT-1:0]             req_vec;
  logic [NPORT-1:0][AW-1:0]     new_addr;
  logic [NPORT-1:0]             eff_pend;
  logic [NPORT-1:0]             cand;
  logic [NPORT-1:0]             gnt_oh;
  logic                         gnt_any;
  logic [AW-1:0]                gnt_addr;

`ifdef ROM_ARB_AGING_EN
  logic [NPORT-1:0][2:0]        starve_q;
  logic [NPORT-1:0]             aged;
`endif

  // Download byte address bit 0 and the upper read lanes are never used.
  logic unused_bits;
  assign unused_bits = ^{DL_ADDR[0], SDRAM_DOUT[63:32]};

  // Port requests and their SDRAM word addresses.
  always_comb begin
    req_vec     = {snd_req, tile_req, spr_req};
    new_addr[0] = SPR_BASE  + AW'({spr_addr, 1'b0});
    new_addr[1] = TILE_BASE + AW'({tile_addr, 1'b0});
    new_addr[2] = SND_BASE  + AW'(snd_addr);
  end

  // Arbitration: pending or same-cycle requests, reads blocked while downloading.
  always_comb begin
    eff_pend = DL_EN ? '0 : (pend_q | req_vec);
    gnt_any  = |eff_pend;
    cand     = eff_pend;
`ifdef ROM_ARB_AGING_EN
    for (int p = 0; p < NPORT; p++) begin
      aged[p] = eff_pend[p] && (32'(starve_q[p]) >= STARVE_LIMIT);
    end
    if (|aged) cand = aged;
`endif
    gnt_oh = '0;
    if (cand[0])      gnt_oh = 3'b001;
    else if (cand[1]) gnt_oh = 3'b010;
    else if (cand[2]) gnt_oh = 3'b100;
    gnt_addr = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (gnt_oh[p]) gnt_addr = req_vec[p] ? new_addr[p] : addr_q[p];
    end
  end

  // Request capture, access sequencing, watchdog and data return.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pend_q      <= '0;
      addr_q      <= '0;
      gnt_oh_q    <= '0;
      quiet_q     <= 1'b0;
      wdog_cnt    <= '0;
      spr_data    <= '0;
      spr_valid   <= 1'b0;
      tile_data   <= '0;
      tile_valid  <= 1'b0;
      snd_data    <= '0;
      snd_valid   <= 1'b0;
      SDRAM_RD    <= 1'b0;
      SDRAM_WR    <= 1'b0;
      SDRAM_BURST <= 1'b0;
      SDRAM_ADDR  <= '0;
      SDRAM_DIN   <= '0;
      SDRAM_BS    <= 2'b00;
      wdog_err    <= 1'b0;
`ifdef ROM_ARB_AGING_EN
      starve_q    <= '0;
`endif
    end else begin
      spr_valid  <= 1'b0;
      tile_valid <= 1'b0;
      snd_valid  <= 1'b0;
      SDRAM_BS   <= 2'b11;

      for (int p = 0; p < NPORT; p++) begin
        if (DL_EN) begin
          pend_q[p] <= 1'b0;
        end else if (req_vec[p]) begin
          pend_q[p] <= 1'b1;
          addr_q[p] <= new_addr[p];
        end
      end
      if (DL_EN) quiet_q <= 1'b1;

      unique case (state)
        IDLE: begin
          SDRAM_ADDR <= '0;
          if (DL_EN && DL_WR) begin
            SDRAM_WR   <= 1'b1;
            SDRAM_ADDR <= DL_ADDR[26:1];
            SDRAM_DIN  <= DL_DATA;
            wdog_cnt   <= '0;
            state      <= WR_ISSUE;
          end else if (SDRAM_READY && gnt_any) begin
            gnt_oh_q    <= gnt_oh;
            quiet_q     <= 1'b0;
            SDRAM_RD    <= 1'b1;
            SDRAM_BURST <= 1'b1;
            SDRAM_ADDR  <= gnt_addr;
            wdog_cnt    <= '0;
            state       <= RD_ISSUE;
            // The granted request is consumed; later requests re-arm it.
            for (int p = 0; p < NPORT; p++) begin
              if (gnt_oh[p]) pend_q[p] <= 1'b0;
            end
`ifdef ROM_ARB_AGING_EN
            for (int p = 0; p < NPORT; p++) begin
              if (gnt_oh[p])
                starve_q[p] <= '0;
              else if (eff_pend[p] && starve_q[p] != 3'h7)
                starve_q[p] <= starve_q[p] + 3'h1;
            end
`endif
          end
        end
        RD_ISSUE: begin
          if (!SDRAM_READY) begin
            SDRAM_RD <= 1'b0;
            state    <= RD_WAIT;
          end else if (wdog_cnt == WDOG_W'(WDOG_MAX - 1)) begin
            // Controller never accepted: abandon and leave the read pending.
            SDRAM_RD    <= 1'b0;
            SDRAM_BURST <= 1'b0;
            SDRAM_ADDR  <= '0;
            wdog_err    <= 1'b1;
            state       <= IDLE;
            for (int p = 0; p < NPORT; p++) begin
              if (gnt_oh_q[p] && !DL_EN) pend_q[p] <= 1'b1;
            end
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
        end
        RD_WAIT: begin
          if (SDRAM_READY) begin
            if (!quiet_q && !DL_EN) begin
              spr_valid  <= gnt_oh_q[0];
              tile_valid <= gnt_oh_q[1];
              snd_valid  <= gnt_oh_q[2];
              if (gnt_oh_q[0]) spr_data  <= SDRAM_DOUT[31:0];
              if (gnt_oh_q[1]) tile_data <= SDRAM_DOUT[31:0];
              if (gnt_oh_q[2]) snd_data  <= SDRAM_DOUT[15:0];
            end
            SDRAM_BURST <= 1'b0;
            SDRAM_ADDR  <= '0;
            state       <= IDLE;
          end
        end
        WR_ISSUE: begin
          if (!SDRAM_READY) begin
            SDRAM_WR <= 1'b0;
            state    <= WR_WAIT;
          end else if (wdog_cnt == WDOG_W'(WDOG_MAX - 1)) begin
            SDRAM_WR   <= 1'b0;
            SDRAM_ADDR <= '0;
            wdog_err   <= 1'b1;
            state      <= IDLE;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
        end
        WR_WAIT: begin
          if (SDRAM_READY) begin
            SDRAM_ADDR <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_sdram_arbiter.sv
// Bench for rom_sdram_arbiter: a simple SDRAM controller model answers
// commands, issued commands and returned data are logged, and the logs are
// compared against expectations derived from the arbitration rules.
// Honours ROM_ARB_AGING_EN for the starvation scenario.
module tb_rom_sdram_arbiter;

  localparam logic [25:0] SPR_BASE  = 26'h0100000;
  localparam logic [25:0] TILE_BASE = 26'h0000000;
  localparam logic [25:0] SND_BASE  = 26'h0200000;

  logic        clk_sys, reset;
  logic        spr_req, tile_req, snd_req;
  logic [18:0] spr_addr;
  logic [17:0] tile_addr;
  logic [19:0] snd_addr;
  logic [31:0] spr_data, tile_data;
  logic [15:0] snd_data;
  logic        spr_valid, tile_valid, snd_valid;
  logic        SDRAM_RD, SDRAM_WR, SDRAM_BURST;
  logic [25:0] SDRAM_ADDR;
  logic [15:0] SDRAM_DIN;
  logic [1:0]  SDRAM_BS;
  logic [63:0] SDRAM_DOUT;
  logic        SDRAM_READY;
  logic        DL_EN, DL_WR;
  logic [26:0] DL_ADDR;
  logic [15:0] DL_DATA;
  logic        wdog_err;

  rom_sdram_arbiter dut (
    .clk_sys(clk_sys), .reset(reset),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_data(spr_data), .spr_valid(spr_valid),
    .tile_req(tile_req), .tile_addr(tile_addr), .tile_data(tile_data), .tile_valid(tile_valid),
    .snd_req(snd_req), .snd_addr(snd_addr), .snd_data(snd_data), .snd_valid(snd_valid),
    .SDRAM_RD(SDRAM_RD), .SDRAM_WR(SDRAM_WR), .SDRAM_BURST(SDRAM_BURST),
    .SDRAM_ADDR(SDRAM_ADDR), .SDRAM_DIN(SDRAM_DIN), .SDRAM_BS(SDRAM_BS),
    .SDRAM_DOUT(SDRAM_DOUT), .SDRAM_READY(SDRAM_READY),
    .DL_EN(DL_EN), .DL_ADDR(DL_ADDR), .DL_DATA(DL_DATA), .DL_WR(DL_WR),
    .wdog_err(wdog_err)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          wr;
    bit          dl;
    logic [25:0] addr;
    logic [15:0] din;
  } iss_t;

  iss_t        iss_q[$];
  logic [31:0] spr_got[$];
  logic [31:0] tile_got[$];
  logic [15:0] snd_got[$];
  bit          respond = 1'b1;
  int          lat = 4;

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // Read data the controller model returns for a given word address.
  function automatic logic [63:0] dfun(input logic [25:0] a);
    return {6'h15, a, 6'h2a, a} ^ 64'h0f0f_3c3c_5a5a_9669;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    iss_q.delete();
    spr_got.delete();
    tile_got.delete();
    snd_got.delete();
  endtask

  task automatic wait_done(input int n_iss, input int n_val, input int budget);
    int i = 0;
    while ((iss_q.size() < n_iss ||
            spr_got.size() + tile_got.size() + snd_got.size() < n_val) && i < budget) begin
      @(negedge clk_sys);
      i++;
    end
    chk("issue_count", 64'(iss_q.size()), 64'(n_iss));
    chk("valid_count", 64'(spr_got.size() + tile_got.size() + snd_got.size()), 64'(n_val));
  endtask

  // SDRAM controller model: READY drops after a command, rises lat+1 cycles later with data.
  initial begin : sdram_model
    int          busy;
    logic [25:0] cur;
    iss_t        e;
    busy        = 0;
    cur         = '0;
    SDRAM_READY = 1'b1;
    SDRAM_DOUT  = '0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        SDRAM_READY = 1'b1;
        busy        = 0;
      end else begin
        if (spr_valid)  spr_got.push_back(spr_data);
        if (tile_valid) tile_got.push_back(tile_data);
        if (snd_valid)  snd_got.push_back(snd_data);
        if (!SDRAM_READY) begin
          if (busy == 0) begin
            SDRAM_READY = 1'b1;
            SDRAM_DOUT  = dfun(cur);
          end else begin
            busy--;
          end
        end else if ((SDRAM_RD || SDRAM_WR) && respond) begin
          e.wr   = SDRAM_WR;
          e.dl   = DL_EN;
          e.addr = SDRAM_ADDR;
          e.din  = SDRAM_DIN;
          iss_q.push_back(e);
          cur         = SDRAM_ADDR;
          busy        = lat;
          SDRAM_READY = 1'b0;
          SDRAM_DOUT  = {$urandom, $urandom};
        end
      end
    end
  end

  initial begin : main
    logic [18:0] sa, sa2;
    logic [17:0] ta, ta2;
    logic [19:0] na;
    logic [2:0]  mask;
    logic [25:0] ea[$];
    logic [63:0] d;
    int          n, idx, ndrop, k;

    reset = 1'b1;
    spr_req = 1'b0; tile_req = 1'b0; snd_req = 1'b0;
    spr_addr = '0; tile_addr = '0; snd_addr = '0;
    DL_EN = 1'b0; DL_WR = 1'b0; DL_ADDR = '0; DL_DATA = '0;

    // Reset state
    @(negedge clk_sys);
    chk("rst_rd", 64'(SDRAM_RD), 64'd0);
    chk("rst_addr", 64'(SDRAM_ADDR), 64'd0);
    chk("rst_bs", 64'(SDRAM_BS), 64'd0);
    chk("rst_valids", 64'({spr_valid, tile_valid, snd_valid}), 64'd0);
    chk("rst_wdog", 64'(wdog_err), 64'd0);
    @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("bs_const", 64'(SDRAM_BS), 64'd3);

    // Random subsets of simultaneous requests: issue order follows spr > tile > snd
    for (int it = 0; it < 8; it++) begin
      clear_logs();
      mask = 3'($urandom_range(1, 7));
      sa = 19'($urandom); ta = 18'($urandom); na = 20'($urandom);
      lat = $urandom_range(2, 6);
      ea.delete();
      if (mask[0]) ea.push_back(SPR_BASE + 26'({sa, 1'b0}));
      if (mask[1]) ea.push_back(TILE_BASE + 26'({ta, 1'b0}));
      if (mask[2]) ea.push_back(SND_BASE + 26'(na));
      spr_req = mask[0]; spr_addr = sa;
      tile_req = mask[1]; tile_addr = ta;
      snd_req = mask[2]; snd_addr = na;
      @(negedge clk_sys);
      spr_req = 1'b0; tile_req = 1'b0; snd_req = 1'b0;
      wait_done(ea.size(), ea.size(), 300);
      for (k = 0; k < ea.size() && k < iss_q.size(); k++) begin
        chk("issue_addr", 64'(iss_q[k].addr), 64'(ea[k]));
        chk("issue_is_read", 64'(iss_q[k].wr), 64'd0);
      end
      chk("spr_cnt", 64'(spr_got.size()), 64'(mask[0]));
      chk("tile_cnt", 64'(tile_got.size()), 64'(mask[1]));
      chk("snd_cnt", 64'(snd_got.size()), 64'(mask[2]));
      if (spr_got.size() > 0) begin
        d = dfun(SPR_BASE + 26'({sa, 1'b0}));
        chk("spr_data", 64'(spr_got[0]), 64'(d[31:0]));
      end
      if (tile_got.size() > 0) begin
        d = dfun(TILE_BASE + 26'({ta, 1'b0}));
        chk("tile_data", 64'(tile_got[0]), 64'(d[31:0]));
      end
      if (snd_got.size() > 0) begin
        d = dfun(SND_BASE + 26'(na));
        chk("snd_data", 64'(snd_got[0]), 64'(d[15:0]));
      end
    end
    @(negedge clk_sys);
    chk("idle_addr_zero", 64'(SDRAM_ADDR), 64'd0);

    // Re-request during own access is served again; repeat tile request overwrites address
    clear_logs();
    lat = 5;
    sa = 19'($urandom); sa2 = 19'($urandom); ta = 18'($urandom); ta2 = 18'($urandom);
    spr_req = 1'b1; spr_addr = sa; tile_req = 1'b1; tile_addr = ta;
    @(negedge clk_sys);
    spr_req = 1'b0; tile_req = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    spr_req = 1'b1; spr_addr = sa2; tile_req = 1'b1; tile_addr = ta2;
    @(negedge clk_sys);
    spr_req = 1'b0; tile_req = 1'b0;
    wait_done(3, 3, 300);
    if (iss_q.size() >= 3) begin
      chk("merge_iss0", 64'(iss_q[0].addr), 64'(SPR_BASE + 26'({sa, 1'b0})));
      chk("merge_iss1", 64'(iss_q[1].addr), 64'(SPR_BASE + 26'({sa2, 1'b0})));
      chk("merge_iss2", 64'(iss_q[2].addr), 64'(TILE_BASE + 26'({ta2, 1'b0})));
    end
    if (tile_got.size() > 0) begin
      d = dfun(TILE_BASE + 26'({ta2, 1'b0}));
      chk("merge_tile_data", 64'(tile_got[0]), 64'(d[31:0]));
    end
    chk("merge_spr_cnt", 64'(spr_got.size()), 64'd2);

    // Held sprite request against a pending sound request
    clear_logs();
    lat = 3;
    sa = 19'($urandom); na = 20'($urandom);
    spr_req = 1'b1; spr_addr = sa; snd_req = 1'b1; snd_addr = na;
    @(negedge clk_sys);
    snd_req = 1'b0;
    k = 0;
    while (iss_q.size() < 6 && k < 300) begin
      @(negedge clk_sys);
      k++;
    end
    chk("starve_progress", 64'(iss_q.size() >= 6), 64'd1);
    ndrop = iss_q.size();
    spr_req = 1'b0;
    repeat (100) @(negedge clk_sys);
    idx = -1;
    for (int j = 0; j < iss_q.size(); j++)
      if (idx < 0 && iss_q[j].addr == SND_BASE + 26'(na)) idx = j;
    for (int j = 0; j < idx; j++)
      chk("starve_spr_addr", 64'(iss_q[j].addr), 64'(SPR_BASE + 26'({sa, 1'b0})));
`ifdef ROM_ARB_AGING_EN
    chk("aged_snd_grant_index", 64'(idx), 64'd4);
`else
    chk("snd_after_spr_drop", 64'(idx >= ndrop), 64'd1);
`endif
    chk("starve_snd_cnt", 64'(snd_got.size()), 64'd1);

    // Download write passes through; reads suppressed while downloading
    clear_logs();
    lat = 3;
    DL_EN = 1'b1;
    repeat (2) @(negedge clk_sys);
    DL_ADDR = 27'h0000402; DL_DATA = 16'hBEEF; DL_WR = 1'b1;
    spr_req = 1'b1; spr_addr = 19'($urandom);
    @(negedge clk_sys);
    DL_WR = 1'b0; spr_req = 1'b0;
    chk("dl_wr", 64'(SDRAM_WR), 64'd1);
    chk("dl_addr", 64'(SDRAM_ADDR), 64'h201);
    chk("dl_din", 64'(SDRAM_DIN), 64'hBEEF);
    chk("dl_no_rd", 64'(SDRAM_RD), 64'd0);
    @(negedge clk_sys);
    chk("dl_wr_drop", 64'(SDRAM_WR), 64'd0);
    repeat (15) @(negedge clk_sys);
    chk("dl_issue_cnt", 64'(iss_q.size()), 64'd1);
    if (iss_q.size() > 0) chk("dl_issue_is_wr", 64'(iss_q[0].wr), 64'd1);
    n = 0;
    foreach (iss_q[j]) if (!iss_q[j].wr && iss_q[j].dl) n++;
    chk("dl_reads", 64'(n), 64'd0);
    DL_EN = 1'b0;
    repeat (20) @(negedge clk_sys);
    chk("dl_req_dropped", 64'(iss_q.size()), 64'd1);

    // Read in flight when download starts: completes without a strobe
    clear_logs();
    lat = 6;
    tile_req = 1'b1; tile_addr = 18'($urandom);
    @(negedge clk_sys);
    tile_req = 1'b0;
    DL_EN = 1'b1;
    repeat (20) @(negedge clk_sys);
    DL_EN = 1'b0;
    repeat (5) @(negedge clk_sys);
    chk("dl_suppress_valid", 64'(tile_got.size()), 64'd0);
    chk("dl_suppress_issue", 64'(iss_q.size()), 64'd1);

    // Watchdog: controller ignores the read
    clear_logs();
    lat = 3;
    chk("wdog_clear", 64'(wdog_err), 64'd0);
    respond = 1'b0;
    sa = 19'($urandom);
    spr_req = 1'b1; spr_addr = sa;
    @(negedge clk_sys);
    spr_req = 1'b0;
    k = 0;
    while (!SDRAM_RD && k < 10) begin
      @(negedge clk_sys);
      k++;
    end
    n = 0;
    while (SDRAM_RD && n < 400) begin
      n++;
      @(negedge clk_sys);
    end
    respond = 1'b1;
    chk("wdog_cycles", 64'(n), 64'd255);
    chk("wdog_rd_drop", 64'(SDRAM_RD), 64'd0);
    chk("wdog_err_set", 64'(wdog_err), 64'd1);
    wait_done(1, 1, 100);
    if (iss_q.size() > 0)
      chk("wdog_retry_addr", 64'(iss_q[0].addr), 64'(SPR_BASE + 26'({sa, 1'b0})));
    if (spr_got.size() > 0) begin
      d = dfun(SPR_BASE + 26'({sa, 1'b0}));
      chk("wdog_retry_data", 64'(spr_got[0]), 64'(d[31:0]));
    end
    chk("wdog_sticky", 64'(wdog_err), 64'd1);

    // Asynchronous reset during the wait phase of a read
    clear_logs();
    lat = 10;
    spr_req = 1'b1; spr_addr = 19'($urandom);
    @(negedge clk_sys);
    spr_req = 1'b0;
    repeat (3) @(negedge clk_sys);
    #2 reset = 1'b1;
    #1;
    chk("arst_rd", 64'(SDRAM_RD), 64'd0);
    chk("arst_burst", 64'(SDRAM_BURST), 64'd0);
    chk("arst_addr", 64'(SDRAM_ADDR), 64'd0);
    chk("arst_bs", 64'(SDRAM_BS), 64'd0);
    chk("arst_wdog", 64'(wdog_err), 64'd0);
    chk("arst_data", 64'({spr_data, tile_data}), 64'd0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (30) @(negedge clk_sys);
    chk("arst_no_valid", 64'(spr_got.size()), 64'd0);
    chk("arst_no_retry", 64'(iss_q.size()), 64'd1);
    clear_logs();
    lat = 2;
    ta = 18'($urandom);
    tile_req = 1'b1; tile_addr = ta;
    @(negedge clk_sys);
    tile_req = 1'b0;
    wait_done(1, 1, 50);
    if (iss_q.size() > 0)
      chk("post_rst_addr", 64'(iss_q[0].addr), 64'(TILE_BASE + 26'({ta, 1'b0})));
    if (tile_got.size() > 0) begin
      d = dfun(TILE_BASE + 26'({ta, 1'b0}));
      chk("post_rst_data", 64'(tile_got[0]), 64'(d[31:0]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_sdram_arbiter.md
Name: rom_sdram_arbiter

Overview:
Shares the single SDRAM controller port between three ROM read clients: sprite ROM, tile ROM and sound sample ROM. It also passes through HPS ROM-download writes.
Each client's request is latched, arbitrated and issued as a burst read. The SDRAM READY handshake is sequenced through an explicit state machine, and the returned data is steered back with a one-cycle valid strobe.
Sits between the video/sound ROM fetchers and the SDRAM controller.

Parameters:
SPR_BASE, 26'h0100000, word base address of the sprite region
TILE_BASE, 26'h0000000, word base address of the tile region
SND_BASE, 26'h0200000, word base address of the sound sample region
STARVE_LIMIT, 4, losing grants tolerated before a pending port is promoted (aging build only)
WDOG_MAX, 255, cycles allowed for READY to fall after issue

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
spr_req  in  1  sprite read request, level sampled each clk_sys
spr_addr  in  19  sprite dword address
spr_data  out  32  sprite read data
spr_valid  out  1  one-cycle strobe: spr_data updated
tile_req  in  1  tile read request
tile_addr  in  18  tile dword address
tile_data  out  32  tile read data
tile_valid  out  1  one-cycle strobe
snd_req  in  1  sound read request
snd_addr  in  20  sound word address
snd_data  out  16  sound read data
snd_valid  out  1  one-cycle strobe
SDRAM_RD  out  1  read command
SDRAM_WR  out  1  write command
SDRAM_BURST  out  1  burst flag
SDRAM_ADDR  out  26  word address [26:1]
SDRAM_DIN  out  16  write data
SDRAM_BS  out  2  byte select, constant 2'b11
SDRAM_DOUT  in  64  read data
SDRAM_READY  in  1  controller idle/ready
DL_EN  in  1  ROM download active
DL_ADDR  in  27  download byte address
DL_DATA  in  16  download data
DL_WR  in  1  download write strobe
wdog_err  out  1  sticky: watchdog expired

Behaviour:
- Clock/reset: already decided — one clock, clk_sys; reset is asynchronous and active-high.
- Reset values: all outputs 0. Internal state: pending flags 0, FSM IDLE, starve counters 0. Reset mid-access abandons the access with no valid strobe.
- Request capture:
  - Any cycle with a port's req high sets that port's pending flag and latches its address.
  - A repeat req while pending (not yet granted) overwrites the address; requests merge, no queueing.
  - A req during that port's own RUN is latched as a new pending request.
- Address map:
  - spr: SPR_BASE + {spr_addr,1'b0}
  - tile: TILE_BASE + {tile_addr,1'b0}
  - snd: SND_BASE + snd_addr
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT.
- IDLE:
  - If DL_EN & DL_WR: latch DL_ADDR[26:1] and DL_DATA, set SDRAM_WR=1, go to WR_ISSUE.
  - Else if ~DL_EN & SDRAM_READY & any pending (or req this cycle): grant, drive SDRAM_ADDR, set SDRAM_RD=1 and SDRAM_BURST=1, go to RD_ISSUE.
  - Grant priority: spr > tile > snd.
  - Latency: req sampled at edge N with FSM in IDLE and READY high → SDRAM_RD=1 after edge N.
- RD_ISSUE: when SDRAM_READY falls, clear SDRAM_RD and go to RD_WAIT.
- RD_WAIT: on SDRAM_READY high, capture data into the granted port, pulse its valid for 1 cycle, clear its pending flag unless re-requested, go to IDLE.
  - spr/tile data = DOUT[31:0]; snd data = DOUT[15:0].
- WR_ISSUE: when READY falls, clear SDRAM_WR and go to WR_WAIT. WR_WAIT returns to IDLE on READY high.
- SDRAM_ADDR holds the granted address for the whole access. In IDLE it is 0.
- DL_EN high:
  - All pending read flags are cleared and read grants are suppressed.
  - A read already in flight completes normally, but its valid strobe is suppressed.
- Watchdog: if READY stays high for WDOG_MAX cycles in either ISSUE state, drop RD/WR, set wdog_err, return to IDLE. The read's pending flag stays set so the access is retried. wdog_err is cleared only by reset.
- Simultaneous capture + completion on the same port: the new request wins; pending stays set.

Optional Feature:
ROM_ARB_AGING_EN:
- Defined: each port has a 3-bit starve counter.
  - Increments when another port is granted while this port is pending.
  - Saturates; cleared on its own grant.
  - A port whose counter is >= STARVE_LIMIT outranks fixed priority; ties resolve spr > tile > snd.
- Undefined: pure fixed priority, no counters.

Test Plan:
1. spr_req, tile_req and snd_req all pulse together, READY model takes 6 cycles per access → grants in order spr, tile, snd; each valid pulses once; addresses 0x100000+2·spr_addr, 2·tile_addr, 0x200000+snd_addr.
2. DL_EN=1, DL_WR pulse with DL_ADDR=0x000402, DL_DATA=0xBEEF → SDRAM_WR=1, SDRAM_ADDR=0x201, SDRAM_DIN=0xBEEF; SDRAM_WR drops on the READY fall; no SDRAM_RD while DL_EN.
3. spr_req held continuously, snd_req pending (aging build, STARVE_LIMIT=4) → snd is granted on the 5th grant; without the macro, snd waits until spr_req drops.
4. READY never falls after issue → after 255 cycles SDRAM_RD=0, wdog_err=1; request is reissued once READY toggles again.
5. Assert reset during RD_WAIT → all outputs 0 immediately (asynchronous); no valid strobe; FSM IDLE after release.
